vend_ctrl: RTL and testbench

VEND_CTRL -- requirements
Module: vend_ctrl

---
 rtl/vend_pkg.sv | 16 +
 rtl/vend_ctrl_if.sv | 40 ++++
 rtl/vend_delay_timer.sv | 36 +++
 rtl/vend_ctrl.sv | 171 +++++++++++++++++
 tb/tb_vend_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared state encoding and default parameter values for the vending controller.
package vend_pkg;

   localparam int unsigned N_ITEMS_DEF     = 4;
   localparam int unsigned CREDIT_W_DEF    = 8;
   localparam int unsigned DELAY_CYC_DEF   = 100;
   localparam int unsigned TIMEOUT_CYC_DEF = 1000;

   typedef enum logic [2:0] {
      StIdle        = 3'd0,
      StSelected    = 3'd1,
      StPayDelay    = 3'd2,
      StChangeDelay = 3'd3
   } vend_state_e;

endpackage

// File: rtl/vend_ctrl_if.sv
// User/product-side signal bundle of the vending controller; the controller is the slave.
interface vend_ctrl_if #(
   parameter int unsigned N_ITEMS  = vend_pkg::N_ITEMS_DEF,
   parameter int unsigned CREDIT_W = vend_pkg::CREDIT_W_DEF
);
   localparam int unsigned IDX_W = $clog2(N_ITEMS);

   logic                        sel_valid;
   logic [IDX_W-1:0]            sel_idx;
   logic                        coin_valid;
   logic [CREDIT_W-1:0]         coin_value;
   logic                        confirm;
   logic                        cancel;
   logic [N_ITEMS*CREDIT_W-1:0] item_price;
   logic [N_ITEMS-1:0]          item_empty;

   logic [CREDIT_W-1:0]         credit;
   logic [IDX_W-1:0]            cur_item;
   logic                        vend_valid;
   logic [IDX_W-1:0]            vend_idx;
   logic                        change_valid;
   logic [CREDIT_W-1:0]         change_amt;
   logic                        coin_reject;
   logic                        deny;
   logic                        busy;
   logic [2:0]                  state;

   modport master (
      output sel_valid, sel_idx, coin_valid, coin_value, confirm, cancel, item_price, item_empty,
      input  credit, cur_item, vend_valid, vend_idx, change_valid, change_amt, coin_reject, deny,
             busy, state
   );

   modport slave (
      input  sel_valid, sel_idx, coin_valid, coin_value, confirm, cancel, item_price, item_empty,
      output credit, cur_item, vend_valid, vend_idx, change_valid, change_amt, coin_reject, deny,
             busy, state
   );

endinterface

// File: rtl/vend_delay_timer.sv
// Shared pay/change delay counter: done pulses in the DELAY_CYC-th cycle after start.
module vend_delay_timer
   import vend_pkg::*;
#(
   parameter int unsigned DELAY_CYC = DELAY_CYC_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic clear,
   output logic done
);
   localparam int unsigned CNT_W = $clog2(DELAY_CYC);

   logic [CNT_W-1:0] cnt_q;
   logic             active_q;

   assign done = active_q && (cnt_q == CNT_W'(DELAY_CYC - 1));

   // start wins over done so a back-to-back delay begins without a gap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (start) begin
         cnt_q    <= '0;
         active_q <= 1'b1;
      end else if (clear || done) begin
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (active_q) begin
         cnt_q    <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: credit accounting, item selection, timed vend and change refund.
// Defining VEND_TIMEOUT_EN adds an inactivity timeout in the SELECTED state.
module vend_ctrl
   import vend_pkg::*;
#(
   parameter int unsigned N_ITEMS     = N_ITEMS_DEF,
   parameter int unsigned CREDIT_W    = CREDIT_W_DEF,
   parameter int unsigned DELAY_CYC   = DELAY_CYC_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input logic       clk,
   input logic       rst_n,
   vend_ctrl_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(N_ITEMS);

   vend_state_e         state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [IDX_W-1:0]    cur_item_q, cur_item_d;
   logic                vend_valid_q, change_valid_q, coin_reject_q, deny_q, busy_q;
   logic [IDX_W-1:0]    vend_idx_q;
   logic [CREDIT_W-1:0] change_amt_q;

   logic [2**IDX_W-1:0] idx_ok;
   logic [CREDIT_W-1:0] price, remain, credit_post_coin;
   logic [CREDIT_W:0]   coin_sum;
   logic                sold_out, open, coin_ok, sel_ok, cancel_hit, confirm_try, confirm_ok;
   logic                pay_done, change_done, timer_done, timer_start, timer_clear, timed_out;

`ifdef VEND_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] to_cnt_q;
   logic            activity;

   assign activity  = bus.sel_valid || bus.coin_valid || bus.confirm || bus.cancel;
   assign timed_out = (state_q == StSelected) && !activity &&
                      (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q <= '0;
      end else if (state_q != StSelected || activity || timed_out) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_q + TO_W'(1);
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYC;
   assign timed_out      = 1'b0;
`endif

   always_comb begin
      price    = '0;
      sold_out = 1'b0;
      for (int i = 0; i < N_ITEMS; i++) begin
         if (cur_item_q == IDX_W'(i)) begin
            price    = bus.item_price[i*CREDIT_W +: CREDIT_W];
            sold_out = bus.item_empty[i];
         end
      end
      for (int i = 0; i < 2**IDX_W; i++) idx_ok[i] = (i < N_ITEMS);
   end

   always_comb begin
      open             = (state_q == StIdle) || (state_q == StSelected);
      coin_sum         = {1'b0, credit_q} + {1'b0, bus.coin_value};
      coin_ok          = bus.coin_valid && open && !coin_sum[CREDIT_W];
      credit_post_coin = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_q;
      sel_ok           = bus.sel_valid && idx_ok[bus.sel_idx];
      cancel_hit       = bus.cancel && open;
      // Confirm is judged on pre-coin credit; a same-cycle coin still lands in credit_d
      confirm_try      = bus.confirm && !bus.cancel && (state_q == StSelected);
      confirm_ok       = confirm_try && (credit_q >= price) && !sold_out;
      pay_done         = (state_q == StPayDelay) && timer_done;
      change_done      = (state_q == StChangeDelay) && timer_done;
      remain           = credit_q - price;

      state_d    = state_q;
      credit_d   = credit_post_coin;
      cur_item_d = cur_item_q;
      case (state_q)
         StIdle: begin
            if (cancel_hit) begin
               state_d = (credit_post_coin != '0) ? StChangeDelay : StIdle;
            end else if (sel_ok) begin
               cur_item_d = bus.sel_idx;
               state_d    = StSelected;
            end
         end
         StSelected: begin
            if (cancel_hit) begin
               state_d = (credit_post_coin != '0) ? StChangeDelay : StIdle;
            end else if (confirm_ok) begin
               state_d = StPayDelay;
            end else if (timed_out) begin
               state_d = (credit_q != '0) ? StChangeDelay : StIdle;
            end else if (sel_ok) begin
               cur_item_d = bus.sel_idx;
            end
         end
         StPayDelay: begin
            if (pay_done) begin
               credit_d = remain;
               state_d  = (remain != '0) ? StChangeDelay : StIdle;
            end
         end
         StChangeDelay: begin
            if (change_done) begin
               credit_d = '0;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Every entry into a delay state (including pay -> change) restarts the timer
      timer_start = (state_d != state_q) &&
                    ((state_d == StPayDelay) || (state_d == StChangeDelay));
      timer_clear = open;
   end

   vend_delay_timer #(
      .DELAY_CYC(DELAY_CYC)
   ) u_delay_timer (
      .clk  (clk),
      .rst_n(rst_n),
      .start(timer_start),
      .clear(timer_clear),
      .done (timer_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         credit_q       <= '0;
         cur_item_q     <= '0;
         vend_valid_q   <= 1'b0;
         vend_idx_q     <= '0;
         change_valid_q <= 1'b0;
         change_amt_q   <= '0;
         coin_reject_q  <= 1'b0;
         deny_q         <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         cur_item_q     <= cur_item_d;
         vend_valid_q   <= pay_done;
         vend_idx_q     <= pay_done ? cur_item_q : '0;
         change_valid_q <= change_done;
         change_amt_q   <= change_done ? credit_q : '0;
         coin_reject_q  <= bus.coin_valid && !coin_ok;
         deny_q         <= confirm_try && !confirm_ok;
         busy_q         <= (state_d == StPayDelay) || (state_d == StChangeDelay);
      end
   end

   assign bus.state        = state_q;
   assign bus.credit       = credit_q;
   assign bus.cur_item     = cur_item_q;
   assign bus.vend_valid   = vend_valid_q;
   assign bus.vend_idx     = vend_idx_q;
   assign bus.change_valid = change_valid_q;
   assign bus.change_amt   = change_amt_q;
   assign bus.coin_reject  = coin_reject_q;
   assign bus.deny         = deny_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl (prices: item0=6, item1=8, item2=12, item3=9).
module tb_vend_ctrl;
   localparam int unsigned DELAY = 100;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n;

   always #5 clk = ~clk;

   vend_ctrl_if #(.N_ITEMS(4), .CREDIT_W(8)) bus ();

   vend_ctrl #(
      .N_ITEMS    (4),
      .CREDIT_W   (8),
      .DELAY_CYC  (DELAY),
      .TIMEOUT_CYC(1000)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic coin(input int v);
      bus.coin_valid = 1'b1;
      bus.coin_value = 8'(v);
      @(negedge clk);
      bus.coin_valid = 1'b0;
      bus.coin_value = '0;
   endtask

   task automatic sel(input int i);
      bus.sel_valid = 1'b1;
      bus.sel_idx   = 2'(i);
      @(negedge clk);
      bus.sel_valid = 1'b0;
      bus.sel_idx   = '0;
   endtask

   task automatic confirm_s();
      bus.confirm = 1'b1;
      @(negedge clk);
      bus.confirm = 1'b0;
   endtask

   task automatic cancel_s();
      bus.cancel = 1'b1;
      @(negedge clk);
      bus.cancel = 1'b0;
   endtask

   // which: 0 vend_valid, 1 change_valid, 2 state==CHANGE_DELAY; k = -1 if budget expires
   task automatic wait_sig(input int which, input int budget, output int k);
      bit hit;
      hit = 1'b0;
      k   = 0;
      while (!hit && k < budget) begin
         @(negedge clk);
         k++;
         case (which)
            0:       hit = bus.vend_valid;
            1:       hit = bus.change_valid;
            default: hit = (bus.state == 3'd3);
         endcase
      end
      if (!hit) k = -1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int pulses;
      rst_n          = 1'b0;
      bus.sel_valid  = 1'b0;
      bus.sel_idx    = '0;
      bus.coin_valid = 1'b0;
      bus.coin_value = '0;
      bus.confirm    = 1'b0;
      bus.cancel     = 1'b0;
      bus.item_price = {8'd9, 8'd12, 8'd8, 8'd6};
      bus.item_empty = '0;
      cyc(2);
      check("rst_state", bus.state, 0);
      check("rst_credit", bus.credit, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_vend", bus.vend_valid, 0);
      check("rst_change_amt", bus.change_amt, 0);
      rst_n = 1'b1;
      cyc(1);

      // Normal purchase with change; strobes during PAY_DELAY are ignored
      coin(5);
      check("t1_credit5", bus.credit, 5);
      coin(5);
      check("t1_credit10", bus.credit, 10);
      sel(1);
      check("t1_sel_state", bus.state, 1);
      check("t1_cur_item", bus.cur_item, 1);
      confirm_s();
      check("t1_pay_state", bus.state, 2);
      check("t1_busy", bus.busy, 1);
      cyc(9);
      bus.cancel = 1'b1; bus.sel_valid = 1'b1; bus.sel_idx = 2'd3;
      bus.coin_valid = 1'b1; bus.coin_value = 8'd4;
      @(negedge clk);
      bus.cancel = 1'b0; bus.sel_valid = 1'b0; bus.sel_idx = '0;
      bus.coin_valid = 1'b0; bus.coin_value = '0;
      check("t1_busy_coin_reject", bus.coin_reject, 1);
      check("t1_busy_credit", bus.credit, 10);
      check("t1_busy_state", bus.state, 2);
      check("t1_busy_cur_item", bus.cur_item, 1);
      wait_sig(0, 200, n);
      check("t1_vend_delay", n, 90);
      check("t1_vend_idx", bus.vend_idx, 1);
      check("t1_credit_after_vend", bus.credit, 2);
      check("t1_change_state", bus.state, 3);
      wait_sig(1, 200, n);
      check("t1_change_delay", n, 100);
      check("t1_change_amt", bus.change_amt, 2);
      check("t1_credit_cleared", bus.credit, 0);
      check("t1_idle", bus.state, 0);
      check("t1_idle_busy", bus.busy, 0);
      cyc(1);
      check("t1_change_pulse_width", bus.change_valid, 0);
      check("t1_change_amt_zero", bus.change_amt, 0);

      // Insufficient credit -> deny
      coin(3);
      sel(1);
      confirm_s();
      check("t2_deny", bus.deny, 1);
      check("t2_state", bus.state, 1);
      check("t2_credit", bus.credit, 3);
      cyc(1);
      check("t2_deny_pulse_width", bus.deny, 0);
      cancel_s();
      check("t2_cancel_state", bus.state, 3);
      wait_sig(1, 200, n);
      check("t2_change_delay", n, 100);
      check("t2_change_amt", bus.change_amt, 3);

      // Credit overflow rejection, and the exact-fit boundary at 255
      coin(250);
      check("t3_credit250", bus.credit, 250);
      coin(10);
      check("t3_reject", bus.coin_reject, 1);
      check("t3_credit_kept", bus.credit, 250);
      cancel_s();
      wait_sig(1, 200, n);
      check("t3_change_amt250", bus.change_amt, 250);
      coin(250);
      coin(5);
      check("t3_credit255", bus.credit, 255);
      check("t3_no_reject", bus.coin_reject, 0);
      coin(1);
      check("t3_reject255", bus.coin_reject, 1);
      check("t3_credit255_kept", bus.credit, 255);
      cancel_s();
      wait_sig(1, 200, n);
      check("t3_change_amt255", bus.change_amt, 255);

      // Sold-out item denied, then another item vended
      bus.item_empty = 4'b0100;
      coin(20);
      sel(2);
      confirm_s();
      check("t4_deny_empty", bus.deny, 1);
      check("t4_state", bus.state, 1);
      sel(0);
      check("t4_reselect", bus.cur_item, 0);
      confirm_s();
      check("t4_pay", bus.state, 2);
      wait_sig(0, 200, n);
      check("t4_vend_delay", n, 100);
      check("t4_vend_idx", bus.vend_idx, 0);
      check("t4_credit", bus.credit, 14);
      cyc(1);
      check("t4_vend_pulse_width", bus.vend_valid, 0);
      wait_sig(1, 200, n);
      check("t4_change_delay", n, 99);
      check("t4_change_amt", bus.change_amt, 14);
      bus.item_empty = '0;

      // Coin + confirm together uses pre-coin credit; exact price ends in IDLE
      coin(7);
      sel(1);
      bus.confirm = 1'b1; bus.coin_valid = 1'b1; bus.coin_value = 8'd1;
      @(negedge clk);
      bus.confirm = 1'b0; bus.coin_valid = 1'b0; bus.coin_value = '0;
      check("t5_deny_precoin", bus.deny, 1);
      check("t5_credit8", bus.credit, 8);
      confirm_s();
      check("t5_pay", bus.state, 2);
      wait_sig(0, 200, n);
      check("t5_vend_delay", n, 100);
      check("t5_credit0", bus.credit, 0);
      check("t5_idle", bus.state, 0);
      check("t5_busy", bus.busy, 0);
      sel(3);
      check("t5_sel3", bus.state, 1);
      cancel_s();
      check("t5_cancel_zero", bus.state, 0);

      // Reset in the middle of PAY_DELAY abandons the transaction
      coin(10);
      sel(0);
      confirm_s();
      cyc(50);
      rst_n = 1'b0;
      #1;
      check("t6_rst_state", bus.state, 0);
      check("t6_rst_credit", bus.credit, 0);
      check("t6_rst_busy", bus.busy, 0);
      cyc(2);
      rst_n = 1'b1;
      pulses = 0;
      repeat (150) begin
         @(negedge clk);
         if (bus.vend_valid || bus.change_valid) pulses++;
      end
      check("t6_no_pulses", pulses, 0);
      check("t6_idle", bus.state, 0);

      // Inactivity in SELECTED
      coin(7);
      sel(1);
`ifdef VEND_TIMEOUT_EN
      wait_sig(2, 1100, n);
      check("t7_timeout_cycles", n, 1000);
`else
      cyc(1100);
      check("t7_still_selected", bus.state, 1);
      check("t7_credit_kept", bus.credit, 7);
      cancel_s();
`endif
      wait_sig(1, 200, n);
      check("t7_change_delay", n, 100);
      check("t7_change_amt", bus.change_amt, 7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
